// File: rtl/zueira_mem_io_bus_if.sv
// ---------------------------------------------------------------------------
// zueira_mem_io_bus_if
// Request/acknowledge bus between the ZueiraI CPU and its data memory /
// memory-mapped I/O subsystem.
//   req   : master -> slave, request strobe, sampled every rising edge
//   we    : master -> slave, 1 = write, 0 = read (qualified by req)
//   addr  : master -> slave, ADDR_W-bit unsigned address
//   wdata : master -> slave, write data
//   rdata : slave -> master, read data, valid while ack = 1
//   ack   : slave -> master, one-cycle completion pulse, latency 1
// ---------------------------------------------------------------------------
interface zueira_mem_io_bus_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (output req, output we, output addr, output wdata,
                  input  rdata, input ack);
  modport slave  (input  req, input we, input addr, input wdata,
                  output rdata, output ack);
endinterface

// File: rtl/zueira_mem_io_bus.sv
// ---------------------------------------------------------------------------
// zueira_mem_io_bus
// Data RAM plus memory-mapped GPIO for the ZueiraI CPU.
// Address map (offsets from IO_BASE, p = port index):
//   below IO_BASE : RAM
//   4p+0 DIR (rw), 4p+1 OUT (rw), 4p+2 IN (ro, synchronised), 4p+3 IE (rw)
//   4*N_PORTS     : PEND, pin-change pending flags, write-1-to-clear
//   anything else : reads 0, writes ignored, still acknowledged
// Ports:
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   bus       : slave side of the request/acknowledge bus
//   port_in   : asynchronous pad inputs, port p at [p*DATA_W +: DATA_W]
//   port_out  : OUT registers
//   port_oe   : DIR registers (1 = drive)
//   irq       : registered OR of PEND, level interrupt request
// ---------------------------------------------------------------------------
module zueira_mem_io_bus #(
  parameter int          DATA_W  = 8,
  parameter int          ADDR_W  = 8,
  parameter int          N_PORTS = 3,
  parameter int unsigned IO_BASE = 'hF0
) (
  input  logic                        clk,
  input  logic                        rst,
  zueira_mem_io_bus_if.slave          bus,
  input  logic [N_PORTS*DATA_W-1:0]   port_in,
  output logic [N_PORTS*DATA_W-1:0]   port_out,
  output logic [N_PORTS*DATA_W-1:0]   port_oe,
  output logic                        irq
);

  localparam logic [ADDR_W-1:0] IO_BASE_A = ADDR_W'(IO_BASE);
  localparam logic [ADDR_W-1:0] PEND_OFF  = ADDR_W'(4 * N_PORTS);
  localparam int                RAM_AW    = (IO_BASE > 1) ? $clog2(IO_BASE) : 1;

  if (N_PORTS < 1 || N_PORTS > DATA_W) begin : g_bad_nports
    $error("N_PORTS must lie in 1..DATA_W");
  end
  if (longint'(IO_BASE) > (longint'(1) << ADDR_W) - longint'(4 * N_PORTS + 1)) begin : g_bad_base
    $error("IO_BASE leaves no room for the I/O block below the top of the address space");
  end

  logic [DATA_W-1:0]         r_mem [IO_BASE];
  logic [DATA_W-1:0]         r_dir [N_PORTS];
  logic [DATA_W-1:0]         r_out [N_PORTS];
  logic [DATA_W-1:0]         r_ie  [N_PORTS];
  logic [N_PORTS-1:0]        r_pend;
  logic [N_PORTS*DATA_W-1:0] r_sync1, r_sync2, r_prev;
  logic                      r_ack, r_irq;
  logic [DATA_W-1:0]         r_rdata;

  logic                      w_is_io, w_wr, w_wr_io;
  logic [ADDR_W-1:0]         w_off;
  logic [DATA_W-1:0]         w_rd_val;
  logic [N_PORTS*DATA_W-1:0] w_chg;
  logic [N_PORTS-1:0]        w_set, w_pend_clr;

  assign w_is_io    = (bus.addr >= IO_BASE_A);
  assign w_off      = bus.addr - IO_BASE_A;
  // A request coinciding with reset is dropped entirely, including its write.
  assign w_wr       = bus.req && bus.we && !rst;
  assign w_wr_io    = w_wr && w_is_io;
  assign w_pend_clr = (w_wr_io && w_off == PEND_OFF) ? bus.wdata[N_PORTS-1:0] : '0;
  assign w_chg      = r_sync2 ^ r_prev;

  always_comb begin
    w_set = '0;
    for (int p = 0; p < N_PORTS; p++)
      w_set[p] = |(w_chg[p*DATA_W +: DATA_W] & r_ie[p]);
  end

  // Read mux works on pre-edge state, so a write returns the old value.
  always_comb begin
    w_rd_val = '0;
    if (!w_is_io) begin
      w_rd_val = r_mem[bus.addr[RAM_AW-1:0]];
    end else if (w_off == PEND_OFF) begin
      w_rd_val = DATA_W'(r_pend);
    end else begin
      for (int p = 0; p < N_PORTS; p++) begin
        if (w_off[ADDR_W-1:2] == (ADDR_W-2)'(p)) begin
          case (w_off[1:0])
            2'd0:    w_rd_val = r_dir[p];
            2'd1:    w_rd_val = r_out[p];
            2'd2:    w_rd_val = r_sync2[p*DATA_W +: DATA_W];
            default: w_rd_val = r_ie[p];
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr && !w_is_io)
      r_mem[bus.addr[RAM_AW-1:0]] <= bus.wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
      r_irq   <= 1'b0;
      r_pend  <= '0;
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      for (int p = 0; p < N_PORTS; p++) begin
        r_dir[p] <= '0;
        r_out[p] <= '0;
        r_ie[p]  <= '0;
      end
    end else begin
      r_ack <= bus.req;
      if (bus.req)
        r_rdata <= w_rd_val;
      r_sync1 <= port_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_irq   <= |r_pend;
      // A new change event beats a simultaneous write-1-to-clear.
      for (int p = 0; p < N_PORTS; p++)
        r_pend[p] <= w_set[p] | (r_pend[p] & ~w_pend_clr[p]);
      for (int p = 0; p < N_PORTS; p++) begin
        if (w_wr_io && w_off[ADDR_W-1:2] == (ADDR_W-2)'(p)) begin
          case (w_off[1:0])
            2'd0:    r_dir[p] <= bus.wdata;
            2'd1:    r_out[p] <= bus.wdata;
            2'd3:    r_ie[p]  <= bus.wdata;
            default: ;
          endcase
        end
      end
    end
  end

  for (genvar p = 0; p < N_PORTS; p++) begin : g_pins
    assign port_out[p*DATA_W +: DATA_W] = r_out[p];
    assign port_oe[p*DATA_W +: DATA_W]  = r_dir[p];
  end

  assign bus.ack   = r_ack;
  assign bus.rdata = r_rdata;
  assign irq       = r_irq;

endmodule
